// File: rtl/branch_sequencer.sv
// Branch sequencer: decodes a conditional branch, borrows the shared ALU
// for the compare, drives the PC-write condition and keeps branch stats.
module branch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        alu_ack,
  input  logic        zero,
  input  logic        lessThan,
  input  logic        clear_stats,
  output logic        alu_req,
  output logic [1:0]  alu_op,
  output logic        PcWriteCond,
  output logic [1:0]  BranchType,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        illegal,
  output logic [15:0] branch_count,
  output logic [15:0] taken_count
);

  localparam logic [6:0] BranchOp = 7'b1100011;
  localparam logic [3:0] WaitLast = 4'd14;
  localparam logic [15:0] CntMax = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE, REQ, EVAL, DONE, ERR
  } state_t;

  state_t state;
  state_t stateNext;

  logic [2:0] f3Q;
  logic [3:0] waitCnt;
  logic       takenQ;
  logic       takenNext;
  logic       accept;
  logic       legal;
  logic [1:0] brType;
  logic [1:0] aluOpDec;

  assign accept = start && (opcode == BranchOp);
  assign legal  = funct3[2] || (funct3[2:1] == 2'b00);

  always_comb begin
    brType   = 2'd0;
    aluOpDec = 2'b00;
    unique case (1'b1)
      (f3Q[2:1] == 2'b00): begin
        brType   = {1'b0, f3Q[0]};
        aluOpDec = 2'b00;
      end
      (f3Q[2:1] == 2'b10): begin
        brType   = f3Q[0] ? 2'd2 : 2'd3;
        aluOpDec = 2'b01;
      end
      (f3Q[2:1] == 2'b11): begin
        brType   = f3Q[0] ? 2'd2 : 2'd3;
        aluOpDec = 2'b10;
      end
      default: ;
    endcase
  end

  // GE-style types are taken when the less-than flag is clear
  always_comb begin
    takenNext = 1'b0;
    case (brType)
      2'd0: takenNext = zero;
      2'd1: takenNext = ~zero;
      2'd2: takenNext = ~lessThan;
      2'd3: takenNext = lessThan;
    endcase
  end

  always_comb begin
    stateNext   = state;
    alu_req     = 1'b0;
    alu_op      = 2'b00;
    PcWriteCond = 1'b0;
    BranchType  = 2'd0;
    busy        = 1'b1;
    done        = 1'b0;
    taken       = 1'b0;
    illegal     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          stateNext = legal ? REQ : ERR;
        end
      end
      REQ: begin
        alu_req = 1'b1;
        alu_op  = aluOpDec;
        if (alu_ack) begin
          stateNext = EVAL;
        end else if (waitCnt == WaitLast) begin
          stateNext = ERR;
        end
      end
      EVAL: begin
        alu_op      = aluOpDec;
        PcWriteCond = 1'b1;
        BranchType  = brType;
        stateNext   = DONE;
      end
      DONE: begin
        done      = 1'b1;
        taken     = takenQ;
        stateNext = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        illegal   = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      f3Q     <= 3'b000;
      waitCnt <= 4'd0;
      takenQ  <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && accept) begin
        f3Q <= funct3;
      end
      if (state == REQ) begin
        waitCnt <= waitCnt + 4'd1;
      end else begin
        waitCnt <= 4'd0;
      end
      if (state == EVAL) begin
        takenQ <= takenNext;
      end
    end
  end

  // a clear request wins over the increment of the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count <= 16'd0;
      taken_count  <= 16'd0;
    end else if (clear_stats) begin
      branch_count <= 16'd0;
      taken_count  <= 16'd0;
    end else if (state == EVAL) begin
      if (branch_count != CntMax) begin
        branch_count <= branch_count + 16'd1;
      end
      if (takenNext && taken_count != CntMax) begin
        taken_count <= taken_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: scripted scenarios, with completions
// scored against a queue of expected outcomes and a counter model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        alu_ack = 1'b0;
  logic        zero = 1'b0;
  logic        lessThan = 1'b0;
  logic        clear_stats = 1'b0;
  logic        alu_req;
  logic [1:0]  alu_op;
  logic        PcWriteCond;
  logic [1:0]  BranchType;
  logic        busy;
  logic        done;
  logic        taken;
  logic        illegal;
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  localparam logic [6:0] BR = 7'b1100011;

  typedef struct packed {
    logic tk;
    logic ill;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [15:0] mBr = 16'd0;
  logic [15:0] mTk = 16'd0;
  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .opcode(opcode),
    .funct3(funct3),
    .alu_ack(alu_ack),
    .zero(zero),
    .lessThan(lessThan),
    .clear_stats(clear_stats),
    .alu_req(alu_req),
    .alu_op(alu_op),
    .PcWriteCond(PcWriteCond),
    .BranchType(BranchType),
    .busy(busy),
    .done(done),
    .taken(taken),
    .illegal(illegal),
    .branch_count(branch_count),
    .taken_count(taken_count)
  );

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [1:0] mType(input logic [2:0] f);
    case (f)
      3'b001:  return 2'd1;
      3'b100:  return 2'd3;
      3'b101:  return 2'd2;
      3'b110:  return 2'd3;
      3'b111:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] mOp(input logic [2:0] f);
    case (f)
      3'b100, 3'b101: return 2'b01;
      3'b110, 3'b111: return 2'b10;
      default:        return 2'b00;
    endcase
  endfunction

  function automatic logic mTaken(
    input logic [2:0] f, input logic z, input logic lt);
    case (f)
      3'b000:         return z;
      3'b001:         return !z;
      3'b101, 3'b111: return !lt;
      default:        return lt;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] f3);
    start  = 1'b1;
    opcode = BR;
    funct3 = f3;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy);
    else passCnt++;
    totalCnt++;
    if ({alu_req, PcWriteCond, done, taken, illegal} !== 5'b0)
      $display("FAIL rst_flags got=%b want=00000",
        {alu_req, PcWriteCond, done, taken, illegal});
    else passCnt++;
    totalCnt++;
    if ({alu_op, BranchType} !== 4'b0)
      $display("FAIL rst_op got=%b want=0000", {alu_op, BranchType});
    else passCnt++;
    totalCnt++;
    if ({branch_count, taken_count} !== 32'd0)
      $display("FAIL rst_cnt got=%h want=0", {branch_count, taken_count});
    else passCnt++;
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_beq();
    sb.push_back(exp_t'{tk: 1'b1, ill: 1'b0});
    mBr = sat(mBr);
    mTk = sat(mTk);
    launch(3'b000);
    totalCnt++;
    if ({busy, alu_req, alu_op} !== 4'b1100)
      $display("FAIL beq_req got=%b want=1100", {busy, alu_req, alu_op});
    else passCnt++;
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    zero = 1'b1;
    totalCnt++;
    if ({PcWriteCond, BranchType, alu_req, done} !== 5'b10000)
      $display("FAIL beq_eval got=%b want=10000",
        {PcWriteCond, BranchType, alu_req, done});
    else passCnt++;
    tick();
    zero = 1'b0;
    totalCnt++;
    if (done !== 1'b1) $display("FAIL beq_done got=%b want=1", done);
    else passCnt++;
    e = sb.pop_front();
    totalCnt++;
    if ({taken, illegal} !== {e.tk, e.ill})
      $display("FAIL beq_taken got=%b want=%b", {taken, illegal}, e);
    else passCnt++;
    totalCnt++;
    if ({branch_count, taken_count} !== {mBr, mTk})
      $display("FAIL beq_cnt got=%h want=%h",
        {branch_count, taken_count}, {mBr, mTk});
    else passCnt++;
    tick();
    totalCnt++;
    if ({busy, done, PcWriteCond} !== 3'b000)
      $display("FAIL beq_idle got=%b want=000", {busy, done, PcWriteCond});
    else passCnt++;
  endtask

  task automatic test_bltu();
    sb.push_back(exp_t'{tk: 1'b0, ill: 1'b0});
    mBr = sat(mBr);
    launch(3'b110);
    totalCnt++;
    if ({alu_req, alu_op} !== 3'b110)
      $display("FAIL bltu_req got=%b want=110", {alu_req, alu_op});
    else passCnt++;
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    zero = 1'b1;
    lessThan = 1'b0;
    totalCnt++;
    if ({PcWriteCond, BranchType, alu_op} !== 5'b11110)
      $display("FAIL bltu_eval got=%b want=11110",
        {PcWriteCond, BranchType, alu_op});
    else passCnt++;
    tick();
    zero = 1'b0;
    totalCnt++;
    if (done !== 1'b1) $display("FAIL bltu_done got=%b want=1", done);
    else passCnt++;
    e = sb.pop_front();
    totalCnt++;
    if ({taken, illegal} !== {e.tk, e.ill})
      $display("FAIL bltu_taken got=%b want=%b", {taken, illegal}, e);
    else passCnt++;
    totalCnt++;
    if ({branch_count, taken_count} !== {mBr, mTk})
      $display("FAIL bltu_cnt got=%h want=%h",
        {branch_count, taken_count}, {mBr, mTk});
    else passCnt++;
    tick();
  endtask

  task automatic test_types();
    logic [2:0] tbl [6];
    logic [2:0] f;
    logic z;
    logic lt;
    logic tk;
    tbl = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 12; i++) begin
      f  = tbl[i % 6];
      z  = i[0];
      lt = i[1];
      tk = mTaken(f, z, lt);
      sb.push_back(exp_t'{tk: tk, ill: 1'b0});
      mBr = sat(mBr);
      if (tk) mTk = sat(mTk);
      launch(f);
      totalCnt++;
      if (alu_op !== mOp(f))
        $display("FAIL types_op f3=%b got=%b want=%b", f, alu_op, mOp(f));
      else passCnt++;
      alu_ack = 1'b1;
      tick();
      alu_ack = 1'b0;
      zero = z;
      lessThan = lt;
      totalCnt++;
      if ({PcWriteCond, BranchType} !== {1'b1, mType(f)})
        $display("FAIL types_eval f3=%b got=%b want=%b",
          f, {PcWriteCond, BranchType}, {1'b1, mType(f)});
      else passCnt++;
      tick();
      zero = 1'b0;
      lessThan = 1'b0;
      e = sb.pop_front();
      totalCnt++;
      if ({done, taken, illegal} !== {1'b1, e.tk, e.ill})
        $display("FAIL types_done f3=%b got=%b want=%b",
          f, {done, taken, illegal}, {1'b1, e.tk, e.ill});
      else passCnt++;
      totalCnt++;
      if ({branch_count, taken_count} !== {mBr, mTk})
        $display("FAIL types_cnt f3=%b got=%h want=%h",
          f, {branch_count, taken_count}, {mBr, mTk});
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [2:0] bad [2];
    bad = '{3'b010, 3'b011};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exp_t'{tk: 1'b0, ill: 1'b1});
      launch(bad[i]);
      totalCnt++;
      if ({done, busy, alu_req, PcWriteCond} !== 4'b1100)
        $display("FAIL ill_err got=%b want=1100",
          {done, busy, alu_req, PcWriteCond});
      else passCnt++;
      e = sb.pop_front();
      totalCnt++;
      if ({taken, illegal} !== {e.tk, e.ill})
        $display("FAIL ill_flags got=%b want=%b", {taken, illegal}, e);
      else passCnt++;
      totalCnt++;
      if ({branch_count, taken_count} !== {mBr, mTk})
        $display("FAIL ill_cnt got=%h want=%h",
          {branch_count, taken_count}, {mBr, mTk});
      else passCnt++;
      tick();
      totalCnt++;
      if ({done, illegal, busy} !== 3'b000)
        $display("FAIL ill_len got=%b want=000", {done, illegal, busy});
      else passCnt++;
    end
    start = 1'b1;
    opcode = 7'b0110011;
    funct3 = 3'b000;
    tick();
    start = 1'b0;
    totalCnt++;
    if ({busy, alu_req, done} !== 3'b000)
      $display("FAIL nonbr_ignored got=%b want=000", {busy, alu_req, done});
    else passCnt++;
  endtask

  task automatic test_timeout();
    int n = 0;
    int reqCycles = 0;
    sb.push_back(exp_t'{tk: 1'b0, ill: 1'b1});
    launch(3'b101);
    while (done !== 1'b1 && n < 40) begin
      if (alu_req === 1'b1) reqCycles++;
      tick();
      n++;
    end
    totalCnt++;
    if (done !== 1'b1) $display("FAIL tmo_done got=%b want=1", done);
    else passCnt++;
    totalCnt++;
    if (reqCycles != 15)
      $display("FAIL tmo_len got=%0d want=15", reqCycles);
    else passCnt++;
    e = sb.pop_front();
    totalCnt++;
    if ({taken, illegal, alu_req} !== {e.tk, e.ill, 1'b0})
      $display("FAIL tmo_err got=%b want=%b",
        {taken, illegal, alu_req}, {e.tk, e.ill, 1'b0});
    else passCnt++;
    totalCnt++;
    if ({branch_count, taken_count} !== {mBr, mTk})
      $display("FAIL tmo_cnt got=%h want=%h",
        {branch_count, taken_count}, {mBr, mTk});
    else passCnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    sb.push_back(exp_t'{tk: 1'b1, ill: 1'b0});
    mBr = sat(mBr);
    mTk = sat(mTk);
    launch(3'b001);
    start = 1'b1;
    funct3 = 3'b000;
    tick();
    start = 1'b0;
    totalCnt++;
    if ({alu_req, PcWriteCond, done} !== 3'b100)
      $display("FAIL b2b_busy got=%b want=100", {alu_req, PcWriteCond, done});
    else passCnt++;
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    zero = 1'b0;
    totalCnt++;
    if (BranchType !== 2'd1)
      $display("FAIL b2b_type got=%0d want=1", BranchType);
    else passCnt++;
    tick();
    e = sb.pop_front();
    totalCnt++;
    if ({done, taken, illegal} !== {1'b1, e.tk, e.ill})
      $display("FAIL b2b_done got=%b want=%b",
        {done, taken, illegal}, {1'b1, e.tk, e.ill});
    else passCnt++;
    tick();
    tick();
    totalCnt++;
    if ({busy, done, alu_req} !== 3'b000)
      $display("FAIL b2b_idle got=%b want=000", {busy, done, alu_req});
    else passCnt++;
  endtask

  task automatic test_clear();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    mBr = 16'd0;
    mTk = 16'd0;
    totalCnt++;
    if ({branch_count, taken_count} !== {mBr, mTk})
      $display("FAIL clr_cnt got=%h want=%h",
        {branch_count, taken_count}, {mBr, mTk});
    else passCnt++;
  endtask

  task automatic test_async_reset();
    logic bad = 1'b0;
    sb.push_back(exp_t'{tk: 1'b1, ill: 1'b0});
    mBr = sat(mBr);
    mTk = sat(mTk);
    launch(3'b000);
    alu_ack = 1'b1;
    zero = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    mBr = 16'd0;
    mTk = 16'd0;
    totalCnt++;
    if ({busy, alu_req, alu_op} !== 4'b0000)
      $display("FAIL arst_now got=%b want=0000", {busy, alu_req, alu_op});
    else passCnt++;
    totalCnt++;
    if ({branch_count, taken_count} !== {mBr, mTk})
      $display("FAIL arst_cnt got=%h want=%h",
        {branch_count, taken_count}, {mBr, mTk});
    else passCnt++;
    tick();
    alu_ack = 1'b0;
    zero = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done !== 1'b0 || PcWriteCond !== 1'b0) bad = 1'b1;
      tick();
    end
    totalCnt++;
    if (bad !== 1'b0)
      $display("FAIL arst_abandon got=%b want=0", bad);
    else passCnt++;
  endtask

  task automatic test_saturation();
    force dut.branch_count = 16'hFFFE;
    force dut.taken_count = 16'hFFFE;
    #1;
    release dut.branch_count;
    release dut.taken_count;
    mBr = 16'hFFFE;
    mTk = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(exp_t'{tk: 1'b1, ill: 1'b0});
      if (k < 2) begin
        mBr = sat(mBr);
        mTk = sat(mTk);
      end else begin
        mBr = 16'd0;
        mTk = 16'd0;
      end
      launch(3'b000);
      alu_ack = 1'b1;
      tick();
      alu_ack = 1'b0;
      zero = 1'b1;
      clear_stats = (k == 2);
      tick();
      zero = 1'b0;
      clear_stats = 1'b0;
      e = sb.pop_front();
      totalCnt++;
      if ({done, taken} !== {1'b1, e.tk})
        $display("FAIL sat_done k=%0d got=%b want=%b",
          k, {done, taken}, {1'b1, e.tk});
      else passCnt++;
      totalCnt++;
      if ({branch_count, taken_count} !== {mBr, mTk})
        $display("FAIL sat_cnt k=%0d got=%h want=%h",
          k, {branch_count, taken_count}, {mBr, mTk});
      else passCnt++;
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq();
    test_bltu();
    test_types();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
